mem_access_stage: RTL

Memory-access stage controller of the pipelined MIPS core, between the EX/MEM latch and the MEM/WB latch. It turns the memory operation held in EX/MEM into a held dcache request (lw, sw, ll, sc) and stalls the pipeline until `dhit`. It also maintains the LL/SC link register with snoop invalidation and latches the load or sc result for the MEM/WB latch.

---
 rtl/mem_access_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM-stage controller. Holds a dcache request for lw/sw/ll/sc
//               until dhit, tracks the LL/SC link and latches the result.
// Revision    : 1.0
// ============================================================================
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic              ex_memRd,
    input  logic              ex_memWr,
    input  logic              ex_ll,
    input  logic              ex_sc,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_halt,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_result,
    output logic              halt_out,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] COMPLETE = 2'd2;

    logic [1:0]        r_state;
    logic              r_is_ll;
    logic              r_is_sc;

    logic              w_memop;
    logic              w_scfail;
    logic              w_halt_set;
    logic              w_link_valid_nx;
    logic [ADDR_W-1:0] w_link_addr_nx;
    logic              w_unused;

    function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

    assign w_memop    = ex_valid & (ex_memRd | ex_memWr | ex_ll | ex_sc);
    assign w_scfail   = ex_sc & ~(link_valid & same_word(link_addr, ex_addr));
    // EX/MEM still holds the finished instruction while in COMPLETE
    assign w_halt_set = ex_valid & ex_halt & (r_state != COMPLETE);
    assign mem_stall  = ((r_state == IDLE) & w_memop & ~halt_out) | (r_state == ACCESS);
    assign w_unused   = &{1'b0, snoop_addr[1:0]};

    // Own completion is applied first so a same-word snoop in that cycle wins
    always_comb begin
        w_link_valid_nx = link_valid;
        w_link_addr_nx  = link_addr;
        if ((r_state == ACCESS) && dhit) begin
            if (r_is_ll) begin
                w_link_valid_nx = 1'b1;
                w_link_addr_nx  = dmemaddr;
            end else if (r_is_sc) begin
                w_link_valid_nx = 1'b0;
            end else if (dmemWEN && same_word(dmemaddr, link_addr)) begin
                w_link_valid_nx = 1'b0;
            end
        end
        if (snoop_inv && same_word(snoop_addr, w_link_addr_nx)) begin
            w_link_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_is_ll    <= 1'b0;
            r_is_sc    <= 1'b0;
            dmemREN    <= 1'b0;
            dmemWEN    <= 1'b0;
            dmemaddr   <= '0;
            dmemstore  <= '0;
            mem_done   <= 1'b0;
            mem_result <= '0;
            halt_out   <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            link_valid <= w_link_valid_nx;
            link_addr  <= w_link_addr_nx;
            mem_done   <= 1'b0;
            if (w_halt_set) begin
                halt_out <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_memop && w_scfail) begin
                        r_state    <= COMPLETE;
                        mem_result <= '0;
                        mem_done   <= 1'b1;
                    end else if (w_memop && !halt_out) begin
                        r_state   <= ACCESS;
                        dmemaddr  <= ex_addr;
                        dmemstore <= ex_wdata;
                        dmemREN   <= ex_memRd | ex_ll;
                        dmemWEN   <= ex_memWr | ex_sc;
                        r_is_ll   <= ex_ll;
                        r_is_sc   <= ex_sc;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        r_state  <= COMPLETE;
                        mem_done <= 1'b1;
                        if (dmemREN) begin
                            mem_result <= dmemload;
                        end else if (r_is_sc) begin
                            mem_result <= DATA_W'(1);
                        end
                    end
                end
                COMPLETE: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
